// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch sequencer states and address constants.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer with branch delay slot
// handling and halt on a redirect to HALT_ADDR.
module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = mips_pkg::HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        instr_ready,
  input  logic [31:0] instr_readdata,
  input  logic        redirect,
  input  logic [31:0] pc_next,
  output logic [31:0] instr_address,
  output logic        instr_read,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        active,
  output logic        in_delay_slot
);
  import mips_pkg::*;

  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            active_q, active_d;
  logic            instr_read_q, instr_read_d;
  logic            in_delay_q, in_delay_d;
  logic            advance;
  logic [XLEN-1:0] pc_plus4;

  // Sequential PC of the current instruction; wraps modulo 2^32
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state, next-PC and status-flag decode
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    advance      = clk_enable & instr_ready & (state_q != HALT);

    if (advance) begin
      case (state_q)
        RUN: begin
          pc_d = pc_plus4;
          if (redirect) begin
            target_d = pc_next;
            state_d  = DELAY;
          end
        end
        DELAY: begin
          // Branches inside a delay slot are undefined, so redirect is not looked at here
          pc_d    = target_q;
          state_d = (target_q == HALT_ADDR) ? HALT : RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    active_d     = (state_d != HALT);
    instr_read_d = (state_d != HALT);
    in_delay_d   = (state_d == DELAY);
  end

  // State and PC registers; synchronous reset overrides the stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      target_q     <= '0;
      active_q     <= 1'b1;
      instr_read_q <= 1'b1;
      in_delay_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      active_q     <= active_d;
      instr_read_q <= instr_read_d;
      in_delay_q   <= in_delay_d;
    end
  end

  assign instr_address = pc_q;
  assign pc            = pc_q;
  assign pc4           = pc_plus4;
  assign instr_read    = instr_read_q;
  assign active        = active_q;
  assign in_delay_slot = in_delay_q;

  // Memory-side signals pass straight through with no added latency
  assign instruction   = instr_readdata;
  assign instr_valid   = instr_read_q & instr_ready & clk_enable;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch with a behavioural reference model.
module tb_pc_fetch;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        instr_ready;
  logic [31:0] instr_readdata;
  logic        redirect;
  logic [31:0] pc_next;
  logic [31:0] instr_address;
  logic        instr_read;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        active;
  logic        in_delay_slot;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: where execution is, whether a branch target is pending, halted or not
  bit [31:0] m_pc;
  bit [31:0] m_target;
  bit        m_pending;
  bit        m_halted;
  bit        m_valid = 0;
  bit        bad_fetch = 0;

  pc_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .instr_ready    (instr_ready),
    .instr_readdata (instr_readdata),
    .redirect       (redirect),
    .pc_next        (pc_next),
    .instr_address  (instr_address),
    .instr_read     (instr_read),
    .pc             (pc),
    .pc4            (pc4),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .active         (active),
    .in_delay_slot  (in_delay_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model for the current cycle
  task automatic compare();
    if (instr_read === 1'b1 && instr_address === 32'h0040_0000) bad_fetch = 1;
    if (!m_valid) return;
    chk("instr_address", instr_address, m_pc);
    chk("pc",            pc,            m_pc);
    chk("pc4",           pc4,           m_pc + 32'd4);
    chk("instr_read",    32'(instr_read),    32'(!m_halted));
    chk("active",        32'(active),        32'(!m_halted));
    chk("in_delay_slot", 32'(in_delay_slot), 32'(m_pending));
    chk("instruction",   instruction,   instr_readdata);
    chk("instr_valid",   32'(instr_valid),
        32'(!m_halted && clk_enable && instr_ready));
  endtask

  // Apply one cycle of inputs, check outputs, then advance the model across the edge
  task automatic apply(input logic rst, input logic ce, input logic rdy,
                       input logic red, input logic [31:0] nxt);
    reset          = rst;
    clk_enable     = ce;
    instr_ready    = rdy;
    redirect       = red;
    pc_next        = nxt;
    instr_readdata = 32'h2400_0000 ^ 32'(n_vec);
    #1;
    compare();
    @(posedge clk);
    if (rst) begin
      m_pc      = RESET_VECTOR;
      m_target  = '0;
      m_pending = 0;
      m_halted  = 0;
      m_valid   = 1;
    end else if (m_valid && !m_halted && ce && rdy) begin
      if (m_pending) begin
        m_pc      = m_target;
        m_pending = 0;
        m_halted  = (m_target == HALT_ADDR);
      end else begin
        if (red) begin
          m_target  = nxt;
          m_pending = 1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) apply(0, 1, 1, 0, 32'h0);
  endtask

  initial begin
    reset = 0; clk_enable = 0; instr_ready = 0; redirect = 0;
    pc_next = '0; instr_readdata = '0;
    @(negedge clk);

    // Reset with clk_enable low still takes effect
    apply(1, 0, 0, 0, 32'h0);
    apply(1, 0, 1, 1, 32'h1234_5678);
    chk("rst_addr",   instr_address, 32'hBFC0_0000);
    chk("rst_active", 32'(active), 32'd1);
    chk("rst_read",   32'(instr_read), 32'd1);
    chk("rst_dslot",  32'(in_delay_slot), 32'd0);

    run(1); chk("seq1", pc, 32'hBFC0_0004);
    run(1); chk("seq2", pc, 32'hBFC0_0008);
    run(1); chk("seq3", pc, 32'hBFC0_000C);
    run(1); chk("seq4", pc, 32'hBFC0_0010);

    // Taken branch to BFC00100
    apply(0, 1, 1, 1, 32'hBFC0_0100);
    chk("br_slot_pc", pc, 32'hBFC0_0014);
    chk("br_slot_ds", 32'(in_delay_slot), 32'd1);

    // Stalls inside the delay slot
    apply(0, 0, 1, 1, 32'h1111_0000);
    apply(0, 0, 1, 0, 32'h0);
    chk("stall_pc", pc, 32'hBFC0_0014);
    apply(0, 1, 0, 1, 32'h2222_0000);
    chk("stall_pc2", pc, 32'hBFC0_0014);

    // Redirect in DELAY is ignored; target preserved across stalls
    reset = 0; clk_enable = 0; instr_ready = 1; #1;
    chk("stall_valid", 32'(instr_valid), 32'd0);
    apply(0, 1, 1, 1, 32'hDEAD_0000);
    chk("br_target", pc, 32'hBFC0_0100);
    chk("br_target_ds", 32'(in_delay_slot), 32'd0);

    // Branch to BFC00020 then halt from there
    apply(0, 1, 1, 1, 32'hBFC0_0020);
    run(1);
    chk("to_20", pc, 32'hBFC0_0020);
    apply(0, 1, 1, 1, 32'h0000_0000);
    chk("halt_slot", pc, 32'hBFC0_0024);
    reset = 0; clk_enable = 1; instr_ready = 1; redirect = 0; #1;
    chk("halt_slot_valid", 32'(instr_valid), 32'd1);
    run(1);
    chk("halt_pc",     pc, 32'h0);
    chk("halt_active", 32'(active), 32'd0);
    chk("halt_read",   32'(instr_read), 32'd0);
    for (int i = 0; i < 10; i++)
      apply(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    chk("halt_hold_pc",  pc, 32'h0);
    chk("halt_hold_act", 32'(active), 32'd0);

    // Reset in the middle of a delay slot discards the pending target
    apply(1, 1, 1, 0, 32'h0);
    apply(0, 1, 1, 1, 32'h0040_0000);
    chk("rd_slot_ds", 32'(in_delay_slot), 32'd1);
    apply(1, 1, 1, 0, 32'h0);
    chk("rd_pc", pc, 32'hBFC0_0000);
    chk("rd_ds", 32'(in_delay_slot), 32'd0);
    run(2);
    chk("rd_run", pc, 32'hBFC0_0008);

    // Reset and redirect in the same cycle: reset wins
    apply(1, 1, 1, 1, 32'h0040_0000);
    chk("rr_pc", pc, 32'hBFC0_0000);
    chk("rr_ds", 32'(in_delay_slot), 32'd0);
    run(1);
    chk("no_0040_fetch", 32'(bad_fetch), 32'd0);

    // PC wrap at the top of the address space does not halt
    apply(0, 1, 1, 1, 32'hFFFF_FFFC);
    run(1);
    chk("wrap_pc",  pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    run(1);
    chk("wrap_next",   pc, 32'h0);
    chk("wrap_active", 32'(active), 32'd1);
    run(1);
    chk("wrap_next2", pc, 32'h4);

    // Unaligned target accepted unchanged
    apply(0, 1, 1, 1, 32'h0000_1002);
    run(1);
    chk("unaligned", pc, 32'h0000_1002);
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the Harvard MIPS core. It holds the architectural PC and drives the instruction-memory address. It feeds `pc`/`pc4` to the combinational next-PC logic and consumes that logic's `pc_next` and `redirect`. It also implements the MIPS branch delay slot and the halt-on-jump-to-zero convention.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000: PC loaded on reset.
- `HALT_ADDR`, default 32'h00000000: a redirect to this address halts the core after the delay slot.

- `clk`  in  1  Single clock; all state updates on its rising edge.
- `reset`  in  1  Synchronous reset, active-high.
- `clk_enable`  in  1  Global stall; 0 freezes all state.
- `instr_ready`  in  1  Instruction memory has valid `instr_readdata` for `instr_address` this cycle.
- `instr_readdata`  in  32  Instruction word from instruction memory.
- `redirect`  in  1  Current instruction is a taken branch or jump.
- `pc_next`  in  32  Target address, valid when `redirect`=1.
- `instr_address`  out  32  Address of the instruction being fetched; equals `pc`.
- `instr_read`  out  1  Fetch request; 1 in RUN/DELAY, 0 in HALT.
- `pc`  out  32  Address of the current instruction.
- `pc4`  out  32  `pc + 4`, modulo 2^32.
- `instruction`  out  32  `instr_readdata` passthrough.
- `instr_valid`  out  1  `instr_read & instr_ready & clk_enable`; the current instruction executes this cycle.
- `active`  out  1  1 until a halt completes.
- `in_delay_slot`  out  1  1 while the current instruction is a delay slot.

## Operation
- States: RUN, DELAY, HALT. `advance` = `clk_enable & instr_ready & (state != HALT)`.
- Reset (synchronous, overrides everything including `clk_enable` = 0):
  - `pc` = RESET_VECTOR, state = RUN, `target_q` = 0.
  - `active` = 1, `instr_read` = 1, `in_delay_slot` = 0.
- RUN with `advance`:
  - `redirect`=0: `pc` <= `pc4`.
  - `redirect`=1: `pc` <= `pc4` (the delay slot), `target_q` <= `pc_next`, state <= DELAY.
- DELAY with `advance`: `pc` <= `target_q`.
  - If `target_q == HALT_ADDR`: state <= HALT.
  - Otherwise: state <= RUN.
  - `redirect` is ignored in DELAY; a branch in a delay slot is architecturally undefined.
- HALT: `pc` = HALT_ADDR, `active` = 0, `instr_read` = 0. Held until reset; all inputs ignored.
- No `advance` (stall or `!instr_ready`): `pc`, state and `target_q` hold. `redirect`/`pc_next` are not sampled.
- `in_delay_slot` = (state == DELAY).
- `pc4` wraps: `pc` = 32'hFFFFFFFC gives `pc4` = 0. A wrap without a redirect does not halt.
- Unaligned `pc_next` is accepted unchanged; fault detection is the decoder's job.

## Timing
- The PC updates one cycle after the instruction is accepted. `instr_address`, `pc`, `pc4`, `active` and `in_delay_slot` are registered-state-derived only.
- `instruction` and `instr_valid` are combinational from memory inputs and have no added latency.
- Branch taken in cycle N (`advance`):
  - Cycle N+1 fetches the delay slot (`pc` N + 4).
  - The target is fetched at the next `advance` after N+1.
- Halt: `active` falls in the cycle after the delay slot is accepted. `instr_read` falls in the same cycle.
- Reset asserted mid-DELAY discards `target_q`. The next cycle fetches RESET_VECTOR in RUN.
- Reset and `redirect` in the same cycle: reset wins.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum {RUN, DELAY, HALT}.
  - `RESET_VECTOR` and `HALT_ADDR` constants, also used by the testbench and the next-PC logic.
- One flat module with no sub-module. State register, `pc`/`target_q` registers and the output decode live in one file.

## Test plan
- Reset sequencing:
  - Assert `reset` with `clk_enable`=0, then release.
  - Required: `instr_address` = BFC00000, `active`=1, `instr_read`=1.
  - With `instr_ready`=1 for 3 cycles, `pc` steps to BFC00004, BFC00008, BFC0000C.
- Taken branch:
  - At `pc`=BFC00010 drive `redirect`=1, `pc_next`=BFC00100.
  - Required `pc` sequence: BFC00014 with `in_delay_slot`=1, then BFC00100 with `in_delay_slot`=0.
- Stalls:
  - In DELAY, drop `clk_enable` for 2 cycles, then drop `instr_ready` for 1 cycle.
  - Required: `pc` holds at BFC00014 throughout and `instr_valid`=0.
  - Afterwards `pc` = BFC00100, with `target_q` preserved.
- Halt:
  - At `pc`=BFC00020 drive `redirect`=1, `pc_next`=0.
  - Required: delay slot BFC00024 executes with `instr_valid`=1.
  - Next cycle: `active`=0, `instr_read`=0, `pc`=0.
  - 10 further cycles with random `redirect`/`pc_next` leave every output unchanged.
- Reset during DELAY:
  - Redirect to 00400000, then assert `reset` while `in_delay_slot`=1.
  - Required: `pc`=BFC00000, state RUN, 00400000 never fetched.
- Wrap and ignored redirect:
  - Force `pc`=FFFFFFFC via a redirect; `pc4` must be 0 and the next `pc`=0 with `active`=1.
  - Separately, `redirect`=1 in DELAY is ignored: `pc_next` is not taken.
